// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one instruction-memory read at a time and hands
// each returned word to decode with its PC. Execute then supplies the next PC.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        next_pc_valid,
    input  logic [31:0] next_pc,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [4:0] {
        S_REQ  = 5'b00001,
        S_WAIT = 5'b00010,
        S_OUT  = 5'b00100,
        S_NPC  = 5'b01000,
        S_ERR  = 5'b10000
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] cnt;
    logic            capture;
    logic            pc_load;
    logic            handshake;
    logic            misaligned;

    assign misaligned   = |next_pc[1:0];
    assign mem_req_addr = pc;
    assign fetch_cnt    = cnt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        pc_load    = 1'b0;
        handshake  = 1'b0;
        case (state)
            S_REQ: begin
                if (mem_req_valid && mem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    capture    = 1'b1;
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_valid && inst_ready) begin
                    handshake = 1'b1;
                    if (next_pc_valid) begin
                        pc_load    = 1'b1;
                        state_next = misaligned ? S_ERR : S_REQ;
                    end else begin
                        state_next = S_NPC;
                    end
                end
            end
            S_NPC: begin
                if (next_pc_valid) begin
                    pc_load    = 1'b1;
                    state_next = misaligned ? S_ERR : S_REQ;
                end
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // Valids are registered from the next state; the request valid being low in
    // reset also keeps the first accept from happening before it is visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc            <= RESET_PC;
            inst          <= '0;
            inst_pc       <= '0;
            inst_valid    <= 1'b0;
            mem_req_valid <= 1'b0;
            fetch_err     <= 1'b0;
            cnt           <= '0;
        end else begin
            mem_req_valid <= (state_next == S_REQ);
            inst_valid    <= (state_next == S_OUT);
            if (capture) begin
                inst    <= mem_rsp_data;
                inst_pc <= pc;
            end
            if (pc_load) begin
                pc <= next_pc;
                if (misaligned) begin
                    fetch_err <= 1'b1;
                end
            end
            if (handshake) begin
                cnt <= cnt + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch: the bench plays memory, decode and execute and
// tracks expected PC, instruction and count per fetch transaction.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] exp_inst;
    logic [31:0] exp_inst_pc;

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .next_pc_valid (next_pc_valid),
        .next_pc       (next_pc),
        .fetch_err     (fetch_err),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        tick();
        tick();
        check("rst_hold_req_valid", 32'(mem_req_valid), 32'd0);
        rst = 1'b1;
        tick();
        exp_pc      = 32'h8000_0000;
        exp_cnt     = 32'd0;
        exp_inst    = 32'd0;
        exp_inst_pc = 32'd0;
    endtask

    // One fetch: request, response, decode handshake, next-PC delivery.
    task automatic txn(input int req_dly, input int rsp_dly, input int hold,
                       input int npc_dly, input logic [31:0] target);
        logic [31:0] data;
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_addr", mem_req_addr, exp_pc);
        for (int i = 0; i < req_dly; i++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'($urandom_range(1));
            mem_rsp_data  = $urandom;
            next_pc_valid = 1'($urandom_range(1));
            next_pc       = $urandom;
            tick();
            check("req_hold_valid", 32'(mem_req_valid), 32'd1);
            check("req_hold_addr", mem_req_addr, exp_pc);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check("wait_req_valid", 32'(mem_req_valid), 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            next_pc_valid = 1'($urandom_range(1));
            next_pc       = $urandom;
            tick();
            check("wait_req_valid", 32'(mem_req_valid), 32'd0);
            check("wait_inst_valid", 32'(inst_valid), 32'd0);
        end
        data          = (rsp_dly == 1 && hold == 5) ? 32'h0000_0013 : $urandom;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        next_pc_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b0;
        exp_inst      = data;
        exp_inst_pc   = exp_pc;
        check("out_inst_valid", 32'(inst_valid), 32'd1);
        check("out_inst", inst, exp_inst);
        check("out_inst_pc", inst_pc, exp_inst_pc);
        check("out_cnt", fetch_cnt, exp_cnt);
        for (int i = 0; i < hold; i++) begin
            inst_ready    = 1'b0;
            mem_rsp_valid = 1'($urandom_range(1));
            mem_rsp_data  = $urandom;
            tick();
            check("hold_inst_valid", 32'(inst_valid), 32'd1);
            check("hold_inst", inst, exp_inst);
            check("hold_inst_pc", inst_pc, exp_inst_pc);
            check("hold_req_valid", 32'(mem_req_valid), 32'd0);
        end
        mem_rsp_valid = 1'b0;
        inst_ready    = 1'b1;
        if (npc_dly == 0) begin
            next_pc_valid = 1'b1;
            next_pc       = target;
        end
        tick();
        inst_ready    = 1'b0;
        next_pc_valid = 1'b0;
        exp_cnt       = exp_cnt + 32'd1;
        check("hs_cnt", fetch_cnt, exp_cnt);
        check("hs_inst_valid", 32'(inst_valid), 32'd0);
        if (npc_dly > 0) begin
            for (int i = 0; i < npc_dly; i++) begin
                check("npc_req_valid", 32'(mem_req_valid), 32'd0);
                check("npc_inst_valid", 32'(inst_valid), 32'd0);
                tick();
            end
            next_pc_valid = 1'b1;
            next_pc       = target;
            tick();
            next_pc_valid = 1'b0;
        end
        exp_pc = target;
        if (target[1:0] != 2'b00) begin
            check("err_flag", 32'(fetch_err), 32'd1);
            for (int i = 0; i < 3; i++) begin
                mem_req_ready = 1'($urandom_range(1));
                mem_rsp_valid = 1'($urandom_range(1));
                inst_ready    = 1'($urandom_range(1));
                next_pc_valid = 1'($urandom_range(1));
                next_pc       = $urandom & 32'hFFFF_FFFC;
                tick();
                check("err_req_valid", 32'(mem_req_valid), 32'd0);
                check("err_inst_valid", 32'(inst_valid), 32'd0);
                check("err_sticky", 32'(fetch_err), 32'd1);
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            inst_ready    = 1'b0;
            next_pc_valid = 1'b0;
        end else begin
            check("no_err", 32'(fetch_err), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] tgt;
        rst           = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        inst_ready    = 1'b0;
        next_pc_valid = 1'b0;
        next_pc       = '0;

        do_reset();
        txn(0, 1, 5, 0, 32'h8000_0004);
        txn(0, 0, 0, 3, 32'h8000_0100);
        txn(1, 2, 1, 0, 32'h8000_0002);
        do_reset();
        check("post_err_clear", 32'(fetch_err), 32'd0);

        // Counter wrap
        force dut.cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cnt;
        exp_cnt = 32'hFFFF_FFFF;
        txn(0, 0, 0, 0, 32'h8000_0004);
        check("wrap_cnt", fetch_cnt, 32'd0);

        // Reset in WAIT, then a late response that must be discarded
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("midwait_req_valid", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("midwait_rst_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        check("late_rsp_inst", inst, 32'd0);
        check("late_rsp_inst_valid", 32'(inst_valid), 32'd0);
        exp_pc      = 32'h8000_0000;
        exp_cnt     = 32'd0;

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(9))
                0:       tgt = $urandom | 32'h1;
                1, 2, 3: tgt = $urandom & 32'hFFFF_FFFC;
                default: tgt = exp_pc + 32'd4;
            endcase
            txn(int'($urandom_range(3)), int'($urandom_range(3)),
                int'($urandom_range(3)), int'($urandom_range(2)), tgt);
            if (tgt[1:0] != 2'b00) begin
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
